// File: rtl/unidade_controle_rodada_if.sv
// Signal bundle between the round controller and its environment (player input and 6-bit sequence counter).
// The master side is the controller; the slave side is the game logic and counter that surround it.
interface unidade_controle_rodada_if;
    logic       iniciar;
    logic       retomar;
    logic       jogada;
    logic       acertou;
    logic       cnt_rco;
    logic       cnt_half_rco;
    logic       cnt_clr_n;
    logic       cnt_ld_n;
    logic       cnt_en;
    logic [5:0] cnt_D;
    logic       pede_jogada;
    logic       metade;
    logic       ganhou;
    logic       perdeu;
    logic       timeout;
    logic [3:0] estado;

    modport master (
        input  iniciar, retomar, jogada, acertou, cnt_rco, cnt_half_rco,
        output cnt_clr_n, cnt_ld_n, cnt_en, cnt_D,
        output pede_jogada, metade, ganhou, perdeu, timeout, estado
    );

    modport slave (
        output iniciar, retomar, jogada, acertou, cnt_rco, cnt_half_rco,
        input  cnt_clr_n, cnt_ld_n, cnt_en, cnt_D,
        input  pede_jogada, metade, ganhou, perdeu, timeout, estado
    );
endinterface

// File: rtl/unidade_controle_rodada.sv
// Round controller: clears the sequence counter, waits for each move with a timeout, advances on correct
// moves and ends in win/error/timeout; a round that passed the midpoint can be resumed from MEIO.
module unidade_controle_rodada #(
    parameter int         TIMEOUT_CYC = 1000,
    parameter logic [5:0] MEIO        = 6'd7
) (
    input logic                         clock,
    input logic                         clr,
    unidade_controle_rodada_if.master   bus
);
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [3:0] {
        INICIAL     = 4'd0,
        PREPARA     = 4'd1,
        ESPERA      = 4'd2,
        REGISTRA    = 4'd3,
        CARREGA     = 4'd4,
        FIM_ACERTO  = 4'd5,
        FIM_ERRO    = 4'd6,
        FIM_TIMEOUT = 4'd7
    } estado_t;

    estado_t       state_q, state_d;
    logic          acertou_r_q, acertou_r_d;
    logic          passou_metade_q, passou_metade_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          cnt_clr_n_q, cnt_clr_n_d;
    logic          cnt_ld_n_q, cnt_ld_n_d;
    logic          cnt_en_q, cnt_en_d;
    logic          pede_jogada_q, pede_jogada_d;
    logic          metade_q, metade_d;
    logic          ganhou_q, ganhou_d;
    logic          perdeu_q, perdeu_d;
    logic          timeout_q, timeout_d;

    always_comb begin
        state_d         = state_q;
        acertou_r_d     = acertou_r_q;
        passou_metade_d = passou_metade_q;
        timer_d         = '0;
        metade_d        = 1'b0;

        case (state_q)
            INICIAL: begin
                if (bus.iniciar) state_d = PREPARA;
            end
            PREPARA: begin
                passou_metade_d = 1'b0;
                state_d         = ESPERA;
            end
            ESPERA: begin
                // The counter holds still in ESPERA, so half_rco seen here is the value REGISTRA would see.
                if (bus.jogada) begin
                    state_d     = REGISTRA;
                    acertou_r_d = bus.acertou;
                    metade_d    = bus.acertou & bus.cnt_half_rco;
                end else if (timer_q == TIMER_MAX) begin
                    state_d = FIM_TIMEOUT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            REGISTRA: begin
                if (metade_q) passou_metade_d = 1'b1;
                if (!acertou_r_q)      state_d = FIM_ERRO;
                else if (bus.cnt_rco)  state_d = FIM_ACERTO;
                else                   state_d = ESPERA;
            end
            CARREGA: begin
                state_d = ESPERA;
            end
            FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
                if (bus.iniciar) begin
                    if (bus.retomar && passou_metade_q && (state_q != FIM_ACERTO)) state_d = CARREGA;
                    else                                                           state_d = PREPARA;
                end
            end
            default: begin
                state_d = bus.iniciar ? PREPARA : INICIAL;
            end
        endcase

        // Outputs are decoded from the next state so they appear registered in the state they belong to.
        cnt_clr_n_d   = (state_d != PREPARA);
        cnt_ld_n_d    = (state_d != CARREGA);
        cnt_en_d      = (state_d == REGISTRA) & acertou_r_d;
        pede_jogada_d = (state_d == ESPERA);
        ganhou_d      = (state_d == FIM_ACERTO);
        perdeu_d      = (state_d == FIM_ERRO);
        timeout_d     = (state_d == FIM_TIMEOUT);
    end

    always_ff @(posedge clock or negedge clr) begin
        if (!clr) begin
            state_q         <= INICIAL;
            acertou_r_q     <= 1'b0;
            passou_metade_q <= 1'b0;
            timer_q         <= '0;
            cnt_clr_n_q     <= 1'b1;
            cnt_ld_n_q      <= 1'b1;
            cnt_en_q        <= 1'b0;
            pede_jogada_q   <= 1'b0;
            metade_q        <= 1'b0;
            ganhou_q        <= 1'b0;
            perdeu_q        <= 1'b0;
            timeout_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            acertou_r_q     <= acertou_r_d;
            passou_metade_q <= passou_metade_d;
            timer_q         <= timer_d;
            cnt_clr_n_q     <= cnt_clr_n_d;
            cnt_ld_n_q      <= cnt_ld_n_d;
            cnt_en_q        <= cnt_en_d;
            pede_jogada_q   <= pede_jogada_d;
            metade_q        <= metade_d;
            ganhou_q        <= ganhou_d;
            perdeu_q        <= perdeu_d;
            timeout_q       <= timeout_d;
        end
    end

    assign bus.cnt_clr_n   = cnt_clr_n_q;
    assign bus.cnt_ld_n    = cnt_ld_n_q;
    assign bus.cnt_en      = cnt_en_q;
    assign bus.cnt_D       = MEIO;
    assign bus.pede_jogada = pede_jogada_q;
    assign bus.metade      = metade_q;
    assign bus.ganhou      = ganhou_q;
    assign bus.perdeu      = perdeu_q;
    assign bus.timeout     = timeout_q;
    assign bus.estado      = state_q;
endmodule

// File: tb/tb_unidade_controle_rodada.sv
// Directed bench for the round controller, with a behavioural 6-bit sequence counter wired to its outputs.
module tb_unidade_controle_rodada;
    localparam int TC = 12;

    logic clock = 1'b0;
    logic clr   = 1'b1;
    always #5 clock = ~clock;

    unidade_controle_rodada_if bus();

    unidade_controle_rodada #(.TIMEOUT_CYC(TC), .MEIO(6'd7)) dut (
        .clock (clock),
        .clr   (clr),
        .bus   (bus)
    );

    // Counter starts at an arbitrary value: only PREPARA may clear it.
    logic [5:0] cnt_q = 6'd42;
    always @(posedge clock) begin
        if (!bus.cnt_clr_n)     cnt_q <= 6'd0;
        else if (!bus.cnt_ld_n) cnt_q <= bus.cnt_D;
        else if (bus.cnt_en)    cnt_q <= cnt_q + 6'd1;
    end
    assign bus.cnt_rco      = (cnt_q == 6'd14);
    assign bus.cnt_half_rco = (cnt_q == 6'd6);

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic start_round(input logic r);
        bus.iniciar = 1'b1;
        bus.retomar = r;
        tick();
        bus.iniciar = 1'b0;
        bus.retomar = 1'b0;
    endtask

    task automatic move(input logic ac, output logic en, output logic md);
        bus.jogada  = 1'b1;
        bus.acertou = ac;
        tick();
        bus.jogada  = 1'b0;
        bus.acertou = 1'b0;
        en = bus.cnt_en;
        md = bus.metade;
        chk("registra_estado", 32'(bus.estado), 3);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        logic en, md;
        int   en_cnt, md_cnt, md_at;
        bus.iniciar = 1'b0;
        bus.retomar = 1'b0;
        bus.jogada  = 1'b0;
        bus.acertou = 1'b0;

        // Reset values
        #1 clr = 1'b0;
        tick();
        tick();
        chk("rst_estado", 32'(bus.estado), 0);
        chk("rst_clr_n", 32'(bus.cnt_clr_n), 1);
        chk("rst_ld_n", 32'(bus.cnt_ld_n), 1);
        chk("rst_flags", {bus.cnt_en, bus.pede_jogada, bus.metade, bus.ganhou, bus.perdeu, bus.timeout}, 0);
        clr = 1'b1;
        tick();
        bus.jogada = 1'b1;
        tick();
        bus.jogada = 1'b0;
        chk("inicial_ignora_jogada", 32'(bus.estado), 0);
        chk("inicial_cnt_intacto", 32'(cnt_q), 42);

        // Full winning round
        start_round(1'b0);
        chk("prep_estado", 32'(bus.estado), 1);
        chk("prep_clr_n", 32'(bus.cnt_clr_n), 0);
        tick();
        chk("espera_estado", 32'(bus.estado), 2);
        chk("espera_pede", 32'(bus.pede_jogada), 1);
        chk("espera_clr_n", 32'(bus.cnt_clr_n), 1);
        chk("espera_cnt0", 32'(cnt_q), 0);
        en_cnt = 0; md_cnt = 0; md_at = 0;
        for (int i = 1; i <= 15; i++) begin
            move(1'b1, en, md);
            en_cnt += int'(en);
            if (md) begin
                md_cnt++;
                md_at = i;
            end
        end
        chk("win_en_pulsos", en_cnt, 15);
        chk("win_metade_pulsos", md_cnt, 1);
        chk("win_metade_jogada", md_at, 7);
        chk("win_estado", 32'(bus.estado), 5);
        chk("win_ganhou", 32'(bus.ganhou), 1);
        chk("win_pede", 32'(bus.pede_jogada), 0);
        chk("win_cnt", 32'(cnt_q), 15);

        // Error on 4th move
        start_round(1'b0);
        tick();
        for (int i = 0; i < 3; i++) move(1'b1, en, md);
        move(1'b0, en, md);
        chk("erro_sem_en", 32'(en), 0);
        chk("erro_estado", 32'(bus.estado), 6);
        chk("erro_perdeu", 32'(bus.perdeu), 1);
        chk("erro_ganhou", 32'(bus.ganhou), 0);
        chk("erro_cnt", 32'(cnt_q), 3);

        // Timeout after exactly TC cycles in ESPERA
        start_round(1'b0);
        tick();
        repeat (TC - 1) tick();
        chk("to_ultimo_ciclo", 32'(bus.estado), 2);
        tick();
        chk("to_estado", 32'(bus.estado), 7);
        chk("to_flag", 32'(bus.timeout), 1);

        // Move on the last cycle beats the timeout
        start_round(1'b0);
        tick();
        repeat (TC - 1) tick();
        move(1'b1, en, md);
        chk("to_jogada_en", 32'(en), 1);
        chk("to_jogada_estado", 32'(bus.estado), 2);
        chk("to_jogada_cnt", 32'(cnt_q), 1);
        bus.iniciar = 1'b1;
        tick();
        bus.iniciar = 1'b0;
        chk("espera_ignora_iniciar", 32'(bus.estado), 2);
        move(1'b0, en, md);
        chk("erro_cedo_estado", 32'(bus.estado), 6);

        // Resume requested before the midpoint falls back to a fresh round
        start_round(1'b1);
        chk("retoma_cedo_prep", 32'(bus.estado), 1);
        tick();
        chk("retoma_cedo_cnt", 32'(cnt_q), 0);

        // 9 correct, error, then resume from MEIO and finish
        for (int i = 0; i < 9; i++) move(1'b1, en, md);
        move(1'b0, en, md);
        chk("meio_erro_cnt", 32'(cnt_q), 9);
        start_round(1'b1);
        chk("carrega_estado", 32'(bus.estado), 4);
        chk("carrega_ld_n", 32'(bus.cnt_ld_n), 0);
        chk("carrega_d", 32'(bus.cnt_D), 7);
        tick();
        chk("carrega_espera", 32'(bus.estado), 2);
        chk("carrega_cnt", 32'(cnt_q), 7);
        chk("carrega_ld_n_sobe", 32'(bus.cnt_ld_n), 1);
        md_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            move(1'b1, en, md);
            md_cnt += int'(md);
        end
        chk("retoma_sem_metade", md_cnt, 0);
        chk("retoma_ganhou", 32'(bus.ganhou), 1);
        chk("retoma_estado", 32'(bus.estado), 5);
        chk("retoma_cnt", 32'(cnt_q), 15);
        start_round(1'b1);
        chk("acerto_retoma_prep", 32'(bus.estado), 1);
        tick();

        // Asynchronous reset mid-ESPERA
        move(1'b1, en, md);
        move(1'b1, en, md);
        #2 clr = 1'b0;
        #1;
        chk("clr_async_estado", 32'(bus.estado), 0);
        chk("clr_async_pede", 32'(bus.pede_jogada), 0);
        chk("clr_async_clr_ld", {bus.cnt_clr_n, bus.cnt_ld_n}, 3);
        chk("clr_async_cnt_en", 32'(bus.cnt_en), 0);
        tick();
        clr = 1'b1;
        tick();
        chk("pos_clr_inicial", 32'(bus.estado), 0);
        chk("pos_clr_cnt_intacto", 32'(cnt_q), 2);
        start_round(1'b0);
        tick();
        chk("pos_clr_espera", 32'(bus.estado), 2);
        chk("pos_clr_cnt0", 32'(cnt_q), 0);
        move(1'b1, en, md);
        chk("pos_clr_cnt1", 32'(cnt_q), 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
